// File: rtl/updown_counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_sequencer
// Description : Initiator-side controller for the 8-bit preset up/down
//               counter. Accepts a count command on a valid/ready handshake,
//               loads the counter preset, enables counting in the commanded
//               direction and counts expiry pulses until the commanded number
//               of repetitions has elapsed. Supports hold (pause) and abort.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_sequencer #(
  parameter int CNT_W  = 8,
  parameter int REPS_W = 4
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [CNT_W-1:0]  cmd_preset,
  input  logic [REPS_W-1:0] cmd_reps,
  input  logic              hold,
  input  logic              abort,
  input  logic              ctr_expired,
  output logic              new_cntr_preset,
  output logic [CNT_W-1:0]  new_cntr_preset_value,
  output logic              enable_cnt_up,
  output logic              enable_cnt_dn,
  output logic              pause_counting,
  output logic              busy,
  output logic [REPS_W:0]   reps_left,
  output logic              done,
  output logic              aborted
);

  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_LOAD = 3'd1;
  localparam logic [2:0] c_ST_GAP  = 3'd2;
  localparam logic [2:0] c_ST_RUN  = 3'd3;
  localparam logic [2:0] c_ST_DONE = 3'd4;

  // A zero repetition field means the full 2^REPS_W range.
  localparam logic [REPS_W:0] c_REPS_FULL = {1'b1, {REPS_W{1'b0}}};
  localparam logic [REPS_W:0] c_REPS_ONE  = {{REPS_W{1'b0}}, 1'b1};

  logic [2:0]      r_state;
  logic            r_dir;
  logic            r_first_run;

  logic [REPS_W:0] w_reps_load;
  logic            w_abort;
  logic            w_expiry_hit;
  logic            w_last_expiry;

  // Command decode, abort qualification and expiry sampling.
  always_comb begin
    w_reps_load   = (cmd_reps == '0) ? c_REPS_FULL : {1'b0, cmd_reps};
    // Abort is honoured only while a command is actually driving the counter.
    w_abort       = abort && ((r_state == c_ST_LOAD) ||
                              (r_state == c_ST_GAP)  ||
                              (r_state == c_ST_RUN));
    // The first RUN cycle is blanked: an expiry there belongs to the counter's
    // previous life, not to this command. The non-zero guard stops underflow.
    w_expiry_hit  = (r_state == c_ST_RUN) && !r_first_run && ctr_expired &&
                    (reps_left != '0);
    w_last_expiry = w_expiry_hit && (reps_left == c_REPS_ONE);
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state               <= c_ST_IDLE;
      r_dir                 <= 1'b0;
      r_first_run           <= 1'b0;
      cmd_ready             <= 1'b1;
      new_cntr_preset       <= 1'b0;
      new_cntr_preset_value <= '0;
      enable_cnt_up         <= 1'b0;
      enable_cnt_dn         <= 1'b0;
      pause_counting        <= 1'b0;
      busy                  <= 1'b0;
      reps_left             <= '0;
      done                  <= 1'b0;
      aborted               <= 1'b0;
    end else begin
      // Strobes are single-cycle by default.
      new_cntr_preset <= 1'b0;
      done            <= 1'b0;
      aborted         <= 1'b0;

      if (w_abort) begin
        r_state        <= c_ST_IDLE;
        r_first_run    <= 1'b0;
        cmd_ready      <= 1'b1;
        busy           <= 1'b0;
        enable_cnt_up  <= 1'b0;
        enable_cnt_dn  <= 1'b0;
        pause_counting <= 1'b0;
        reps_left      <= '0;
        aborted        <= 1'b1;
      end else begin
        case (r_state)
          c_ST_IDLE: begin
            if (cmd_valid) begin
              r_state               <= c_ST_LOAD;
              r_dir                 <= cmd_dir;
              new_cntr_preset_value <= cmd_preset;
              reps_left             <= w_reps_load;
              new_cntr_preset       <= 1'b1;
              cmd_ready             <= 1'b0;
              busy                  <= 1'b1;
            end
          end
          c_ST_LOAD: begin
            // Preset strobe drops; counter stores the preset during GAP.
            r_state <= c_ST_GAP;
          end
          c_ST_GAP: begin
            // Enables rise here so the counter sees a clean rising edge.
            r_state        <= c_ST_RUN;
            r_first_run    <= 1'b1;
            enable_cnt_up  <= !r_dir;
            enable_cnt_dn  <= r_dir;
            pause_counting <= 1'b0;
          end
          c_ST_RUN: begin
            r_first_run <= 1'b0;
            if (w_expiry_hit) begin
              reps_left <= reps_left - c_REPS_ONE;
            end
            if (w_last_expiry) begin
              r_state        <= c_ST_DONE;
              enable_cnt_up  <= 1'b0;
              enable_cnt_dn  <= 1'b0;
              pause_counting <= 1'b0;
              done           <= 1'b1;
            end else begin
              pause_counting <= hold;
            end
          end
          c_ST_DONE: begin
            r_state   <= c_ST_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
          default: begin
            r_state        <= c_ST_IDLE;
            r_first_run    <= 1'b0;
            cmd_ready      <= 1'b1;
            busy           <= 1'b0;
            enable_cnt_up  <= 1'b0;
            enable_cnt_dn  <= 1'b0;
            pause_counting <= 1'b0;
            reps_left      <= '0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_counter_sequencer
// Description : Self-checking bench for updown_counter_sequencer. A timeline
//               model (age since accept, expiries still owed) predicts every
//               output each cycle; directed runs also pin absolute latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_counter_sequencer;

  logic       clk = 1'b0;
  logic       resetb;
  logic       cmd_valid;
  logic       cmd_dir;
  logic [7:0] cmd_preset;
  logic [3:0] cmd_reps;
  logic       hold;
  logic       abort;
  logic       ctr_expired;
  logic       cmd_ready;
  logic       new_cntr_preset;
  logic [7:0] new_cntr_preset_value;
  logic       enable_cnt_up;
  logic       enable_cnt_dn;
  logic       pause_counting;
  logic       busy;
  logic [4:0] reps_left;
  logic       done;
  logic       aborted;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  // Stimulus source for ctr_expired: directed pulses or a bench counter model.
  logic stim_exp = 1'b0;
  logic use_ctr  = 1'b0;
  logic ctr_exp_m;
  int   cnt;

  updown_counter_sequencer #(.CNT_W(8), .REPS_W(4)) dut (
    .clk                   (clk),
    .resetb                (resetb),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_dir               (cmd_dir),
    .cmd_preset            (cmd_preset),
    .cmd_reps              (cmd_reps),
    .hold                  (hold),
    .abort                 (abort),
    .ctr_expired           (ctr_expired),
    .new_cntr_preset       (new_cntr_preset),
    .new_cntr_preset_value (new_cntr_preset_value),
    .enable_cnt_up         (enable_cnt_up),
    .enable_cnt_dn         (enable_cnt_dn),
    .pause_counting        (pause_counting),
    .busy                  (busy),
    .reps_left             (reps_left),
    .done                  (done),
    .aborted               (aborted)
  );

  always #5 clk = ~clk;

  // Output bundle: ready[20] strobe[19] value[18:11] up[10] dn[9] pause[8]
  // busy[7] reps_left[6:2] done[1] aborted[0]
  logic [20:0] act;
  assign act = {cmd_ready, new_cntr_preset, new_cntr_preset_value, enable_cnt_up,
                enable_cnt_dn, pause_counting, busy, reps_left, done, aborted};

  assign ctr_expired = use_ctr ? ctr_exp_m : stim_exp;

  // Up-counting counter stand-in: preset load clears it, it counts while
  // enabled and not paused, and pulses expiry (registered) on reaching preset.
  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt       <= 0;
      ctr_exp_m <= 1'b0;
    end else if (new_cntr_preset) begin
      cnt       <= 0;
      ctr_exp_m <= 1'b0;
    end else if (enable_cnt_up && !pause_counting) begin
      if (cnt == int'(new_cntr_preset_value)) begin
        cnt       <= 0;
        ctr_exp_m <= 1'b1;
      end else begin
        cnt       <= cnt + 1;
        ctr_exp_m <= 1'b0;
      end
    end else begin
      ctr_exp_m <= 1'b0;
    end
  end

  // Timeline model: age counts cycles since accept (1 = preset load,
  // 2 = gap, 3+ = running); m_fin marks the single completion cycle.
  logic       m_active = 1'b0;
  logic       m_fin    = 1'b0;
  int         m_age    = 0;
  logic       m_dir    = 1'b0;
  logic [7:0] m_preset = 8'd0;
  int         m_left   = 0;
  logic       m_pause  = 1'b0;
  logic       m_done   = 1'b0;
  logic       m_abort  = 1'b0;

  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      m_active = 1'b0; m_fin = 1'b0; m_age = 0; m_dir = 1'b0; m_preset = 8'd0;
      m_left = 0; m_pause = 1'b0; m_done = 1'b0; m_abort = 1'b0;
    end else begin
      m_done  = 1'b0;
      m_abort = 1'b0;
      m_pause = 1'b0;
      if (!m_active) begin
        if (cmd_valid) begin
          m_active = 1'b1; m_fin = 1'b0; m_age = 1;
          m_dir = cmd_dir; m_preset = cmd_preset;
          m_left = (cmd_reps == 4'd0) ? 16 : int'(cmd_reps);
        end
      end else if (m_fin) begin
        m_active = 1'b0;
      end else if (abort) begin
        m_active = 1'b0; m_left = 0; m_abort = 1'b1;
      end else begin
        if (m_age >= 4 && ctr_expired && m_left > 0) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_fin = 1'b1; m_done = 1'b1;
          end
        end
        if (m_age >= 3 && !m_fin) m_pause = hold;
        m_age = m_age + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  logic [20:0] exp_vec;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_vec = {!m_active,
                 m_active && !m_fin && (m_age == 1),
                 m_preset,
                 m_active && !m_fin && (m_age >= 3) && !m_dir,
                 m_active && !m_fin && (m_age >= 3) && m_dir,
                 m_pause,
                 m_active,
                 5'(m_left),
                 m_done,
                 m_abort};
      check("cycle_outputs", {11'd0, act}, {11'd0, exp_vec});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command and steps cycle by cycle; n is the cycle offset from
  // the accepting edge (n = 1 is the preset-load cycle).
  task automatic run_cmd(
    input  logic dir, input logic [7:0] preset, input logic [3:0] reps,
    input  logic [63:0] emask, input int hold_at, input int hold_len,
    input  int abort_at, input int busy_at, input int rst_at,
    output int n, output logic got_done, output logic got_abort,
    output logic [20:0] first_vec, output logic [20:0] pre_vec,
    output logic [20:0] last_vec, output int nstrobe, output int npause,
    output logic up_seen, output logic dn_seen);
    logic fin;
    n = 0; got_done = 1'b0; got_abort = 1'b0; fin = 1'b0;
    first_vec = '0; pre_vec = '0; last_vec = '0;
    nstrobe = 0; npause = 0; up_seen = 1'b0; dn_seen = 1'b0;
    cmd_valid = 1'b1; cmd_dir = dir; cmd_preset = preset; cmd_reps = reps;
    stim_exp = 1'b0;
    while (!fin) begin
      tick();
      n++;
      if (n == 1) first_vec = act;
      nstrobe += int'(new_cntr_preset);
      npause  += int'(pause_counting);
      if (enable_cnt_up) up_seen = 1'b1;
      if (enable_cnt_dn) dn_seen = 1'b1;
      if (done) got_done = 1'b1;
      if (aborted) got_abort = 1'b1;
      if (got_done || got_abort) begin
        last_vec = act;
        fin = 1'b1;
      end else if (n == rst_at) begin
        pre_vec = act;
        resetb = 1'b0;
        #1;
        last_vec = act;
        fin = 1'b1;
      end else if (n >= 300) begin
        checks++;
        errors++;
        $display("FAIL timeout: no done/aborted after %0d cycles, required one", n);
        fin = 1'b1;
      end else begin
        cmd_valid = (n == busy_at);
        if (n == busy_at) begin
          cmd_reps   = 4'd9;
          cmd_preset = 8'hAA;
        end
        stim_exp = (n < 64) ? emask[n[5:0]] : 1'b0;
        hold     = (n >= hold_at) && (n < hold_at + hold_len);
        abort    = (n == abort_at);
      end
    end
    cmd_valid = 1'b0; hold = 1'b0; abort = 1'b0; stim_exp = 1'b0;
  endtask

  int          n_o, nstr, npz;
  logic        gd, ga, ups, dns;
  logic [20:0] fv, pv, lv;

  initial begin
    resetb = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_preset = 8'd0;
    cmd_reps = 4'd0; hold = 1'b0; abort = 1'b0;
    #1 resetb = 1'b0;

    // Reset held with a command pending: reset values, nothing accepted.
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_preset = 8'd7; cmd_reps = 4'd1;
    repeat (3) tick();
    check("reset_outputs", {11'd0, act}, 32'h0010_0000);
    chk_en = 1'b1;
    resetb = 1'b1;
    // First edge after release accepts; one expiry at n=4 completes at n=5.
    run_cmd(1'b0, 8'd7, 4'd1, 64'h10, 0, 0, 0, 0, 0,
            n_o, gd, ga, fv, pv, lv, nstr, npz, ups, dns);
    check("t1_strobe_first_edge", {31'd0, fv[19]}, 32'd1);
    check("t1_reps_at_load", {27'd0, fv[6:2]}, 32'd1);
    check("t1_done_latency", n_o, 32'd5);
    check("t1_done", {31'd0, gd}, 32'd1);
    repeat (2) tick();

    // Up, preset 5, reps 2 with the counter model closing the loop.
    use_ctr = 1'b1;
    run_cmd(1'b0, 8'd5, 4'd2, 64'h0, 0, 0, 0, 0, 0,
            n_o, gd, ga, fv, pv, lv, nstr, npz, ups, dns);
    check("t2_done_latency", n_o, 32'd16);
    check("t2_strobe_count", nstr, 32'd1);
    check("t2_preset_value", {24'd0, fv[18:11]}, 32'd5);
    check("t2_up_seen", {31'd0, ups}, 32'd1);
    check("t2_dn_never", {31'd0, dns}, 32'd0);
    repeat (2) tick();

    // Down, reps 0 => 16; expiries every cycle from LOAD onward, so the
    // LOAD/GAP/first-RUN pulses must all be ignored.
    use_ctr = 1'b0;
    run_cmd(1'b1, 8'd3, 4'd0, 64'h0000_0000_000F_FFFE, 0, 0, 0, 0, 0,
            n_o, gd, ga, fv, pv, lv, nstr, npz, ups, dns);
    check("t3_reps_expanded", {27'd0, fv[6:2]}, 32'd16);
    check("t3_done_latency", n_o, 32'd20);
    check("t3_up_never", {31'd0, ups}, 32'd0);
    check("t3_dn_seen", {31'd0, dns}, 32'd1);
    repeat (2) tick();

    // Up, preset 10, reps 1: unheld reference, then held 20 cycles.
    use_ctr = 1'b1;
    run_cmd(1'b0, 8'd10, 4'd1, 64'h0, 0, 0, 0, 0, 0,
            n_o, gd, ga, fv, pv, lv, nstr, npz, ups, dns);
    check("t4_unheld_latency", n_o, 32'd15);
    repeat (2) tick();
    run_cmd(1'b0, 8'd10, 4'd1, 64'h0, 5, 20, 0, 0, 0,
            n_o, gd, ga, fv, pv, lv, nstr, npz, ups, dns);
    check("t4_held_latency", n_o, 32'd35);
    check("t4_pause_cycles", npz, 32'd20);
    repeat (2) tick();

    // Abort during GAP.
    use_ctr = 1'b0;
    run_cmd(1'b0, 8'd9, 4'd2, 64'h0, 0, 0, 2, 0, 0,
            n_o, gd, ga, fv, pv, lv, nstr, npz, ups, dns);
    check("t5a_abort_latency", n_o, 32'd3);
    check("t5a_aborted", {30'd0, ga, gd}, 32'd2);
    check("t5a_ready_en", {29'd0, lv[20], lv[10], lv[9]}, 32'd4);
    repeat (2) tick();

    // Abort coincident with the final expiry: abort wins.
    run_cmd(1'b0, 8'd9, 4'd1, 64'h20, 0, 0, 5, 0, 0,
            n_o, gd, ga, fv, pv, lv, nstr, npz, ups, dns);
    check("t5b_abort_latency", n_o, 32'd6);
    check("t5b_aborted", {30'd0, ga, gd}, 32'd2);
    check("t5b_reps_cleared", {27'd0, lv[6:2]}, 32'd0);
    repeat (2) tick();

    // Command offered while busy is ignored; async reset mid-RUN.
    run_cmd(1'b0, 8'd20, 4'd3, 64'h20, 0, 0, 0, 8, 12,
            n_o, gd, ga, fv, pv, lv, nstr, npz, ups, dns);
    check("t6_reps_unchanged", {27'd0, pv[6:2]}, 32'd2);
    check("t6_preset_unchanged", {24'd0, pv[18:11]}, 32'd20);
    check("t6_async_reset", {11'd0, lv}, 32'h0010_0000);
    check("t6_no_pulse", {30'd0, ga, gd}, 32'd0);
    repeat (2) tick();
    resetb = 1'b1;
    repeat (2) tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
